// File: rtl/load_store_unit_pkg.sv
// Shared op codes, FSM encodings and alignment helpers for the load/store unit.
package load_store_unit_pkg;

    localparam int WORD_WIDTH = 32;

    typedef enum logic [2:0] {
        MEM_OP_LW  = 3'd0,
        MEM_OP_LH  = 3'd1,
        MEM_OP_LHU = 3'd2,
        MEM_OP_LB  = 3'd3,
        MEM_OP_LBU = 3'd4,
        MEM_OP_SW  = 3'd5,
        MEM_OP_SH  = 3'd6,
        MEM_OP_SB  = 3'd7
    } mem_op_e;

    typedef enum logic [1:0] {
        LSU_IDLE  = 2'd0,
        LSU_READ  = 2'd1,
        LSU_WRITE = 2'd2,
        LSU_RESP  = 2'd3
    } lsu_state_e;

    function automatic logic lsu_is_store(input mem_op_e op);
        return (op == MEM_OP_SW) || (op == MEM_OP_SH) || (op == MEM_OP_SB);
    endfunction

    function automatic logic lsu_aligned(input mem_op_e op, input logic [1:0] addr_lo);
        case (op)
            MEM_OP_LW, MEM_OP_SW:               return addr_lo == 2'b00;
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH:   return addr_lo[0] == 1'b0;
            default:                            return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_lane.sv
// Little-endian lane extract/extend for loads and lane merge for sub-word stores.
module lsu_lane
    import load_store_unit_pkg::*;
#(
    parameter int W = WORD_WIDTH
) (
    input  mem_op_e        i_op,
    input  logic [1:0]     i_addr_lo,
    input  logic [W-1:0]   i_word,
    input  logic [W-1:0]   i_wdata,
    output logic [W-1:0]   o_load_val,
    output logic [W-1:0]   o_merged_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

        case (i_op)
            MEM_OP_LW:  o_load_val = i_word;
            MEM_OP_LH:  o_load_val = {{(W-16){w_half[15]}}, w_half};
            MEM_OP_LHU: o_load_val = {{(W-16){1'b0}}, w_half};
            MEM_OP_LB:  o_load_val = {{(W-8){w_byte[7]}}, w_byte};
            MEM_OP_LBU: o_load_val = {{(W-8){1'b0}}, w_byte};
            default:    o_load_val = '0;
        endcase

        o_merged_word = i_word;
        case (i_op)
            MEM_OP_SW: o_merged_word = i_wdata;
            MEM_OP_SH: begin
                if (i_addr_lo[1]) o_merged_word[31:16] = i_wdata[15:0];
                else              o_merged_word[15:0]  = i_wdata[15:0];
            end
            MEM_OP_SB: o_merged_word[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
            default:   o_merged_word = i_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// CPU-side initiator for the word-only data memory: sub-word loads by lane
// extraction, sub-word stores by read-modify-write.
//
// state     | meaning
// ----------+--------------------------------------------------------
// LSU_IDLE  | ready; capture request and check alignment
// LSU_READ  | read_en; register load result or merged store word
// LSU_WRITE | write_en; memory commits the buffered word
// LSU_RESP  | resp_valid for one cycle, then back to idle
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int W    = WORD_WIDTH,
    parameter int OP_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [OP_W-1:0] req_op,
    input  logic [W-1:0]    req_addr,
    input  logic [W-1:0]    req_wdata,
    output logic            resp_valid,
    output logic [W-1:0]    resp_rdata,
    output logic            resp_err,
    output logic            read_en,
    output logic [W-1:0]    read_addr,
    input  logic [W-1:0]    read_data,
    output logic            write_en,
    output logic [W-1:0]    write_addr,
    output logic [W-1:0]    write_data
);

    lsu_state_e   r_state;
    mem_op_e      r_op;
    logic [W-1:0] r_addr;
    logic [W-1:0] r_wdata;
    logic [W-1:0] r_wbuf;

    mem_op_e      w_req_op;
    logic [W-1:0] w_load_val;
    logic [W-1:0] w_merged;

    assign w_req_op = mem_op_e'(req_op);

    lsu_lane #(.W(W)) u_lane (
        .i_op          (r_op),
        .i_addr_lo     (r_addr[1:0]),
        .i_word        (read_data),
        .i_wdata       (r_wdata),
        .o_load_val    (w_load_val),
        .o_merged_word (w_merged)
    );

    // Gating with rst keeps a reset asserted mid-WRITE from committing the store.
    assign req_ready  = (r_state == LSU_IDLE);
    assign read_en    = (r_state == LSU_READ) && rst;
    assign write_en   = (r_state == LSU_WRITE) && rst;
    assign read_addr  = {r_addr[W-1:2], 2'b00};
    assign write_addr = {r_addr[W-1:2], 2'b00};
    assign write_data = r_wbuf;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= LSU_IDLE;
            r_op       <= MEM_OP_LW;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wbuf     <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (r_state)
                LSU_IDLE: begin
                    if (req_valid) begin
                        r_op    <= w_req_op;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_wbuf  <= req_wdata;
                        if (!lsu_aligned(w_req_op, req_addr[1:0])) begin
                            resp_valid <= 1'b1;
                            resp_rdata <= '0;
                            resp_err   <= 1'b1;
                            r_state    <= LSU_RESP;
                        end else if (w_req_op == MEM_OP_SW) begin
                            r_state <= LSU_WRITE;
                        end else begin
                            r_state <= LSU_READ;
                        end
                    end
                end
                LSU_READ: begin
                    if (lsu_is_store(r_op)) begin
                        r_wbuf  <= w_merged;
                        r_state <= LSU_WRITE;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_rdata <= w_load_val;
                        resp_err   <= 1'b0;
                        r_state    <= LSU_RESP;
                    end
                end
                LSU_WRITE: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                    r_state    <= LSU_RESP;
                end
                default: begin
                    r_state <= LSU_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- CPU-side initiator for the word-only simulation/data memory.
- Accepts one load/store request at a time from the multicycle datapath.
- Drives the memory's read/write ports with word-aligned addresses.
- Implements sub-word loads (byte/half, signed/unsigned) by lane extraction, and sub-word stores by read-modify-write.
- Returns the load result or completion, plus an alignment error flag, to the MEM stage.

Parameters:
- W, `WORD_WIDTH (32): data and address width.
- OP_W, 3: width of the memory op code.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle, request accepted when req_valid && req_ready.
- req_op  in  OP_W  op code: LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7.
- req_addr  in  W  byte address.
- req_wdata  in  W  store data; low byte/half used for SB/SH.
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_rdata  out  W  load result (sign/zero-extended); 0 for stores and errors.
- resp_err  out  1  misaligned access, valid with resp_valid.
- read_en  out  1  memory read enable.
- read_addr  out  W  word-aligned address {addr[W-1:2],2'b00}.
- read_data  in  W  memory data, combinational, same cycle as read_addr.
- write_en  out  1  memory write enable; memory commits at posedge.
- write_addr  out  W  word-aligned address.
- write_data  out  W  full merged word.

Behaviour:
- Reset (rst==0 at posedge): state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0; request registers cleared.
- Memory outputs are combinational decodes of state:
  - read_en=(state==READ) && rst.
  - write_en=(state==WRITE) && rst.
  - Consequence: a reset asserted during the WRITE cycle suppresses the memory write.
- Request registers (op, addr, wdata) are captured on accept.
- req_ready=(state==IDLE). Requests are ignored in any other state.
- States: IDLE, READ, WRITE, RESP.
- Alignment check at accept:
  - Half ops require addr[0]==0; word ops require addr[1:0]==0; byte ops are always aligned.
  - Misaligned request: go to RESP directly with err=1, rdata=0. No memory access. resp_valid at accept+1.
- Loads (aligned): IDLE→READ→RESP.
  - In READ, read_data is sampled and the result registered.
  - resp_valid at accept+2.
- SW: IDLE→WRITE→RESP.
  - write_data=wdata.
  - resp_valid at accept+2.
- SH/SB: IDLE→READ→WRITE→RESP.
  - READ registers the old word.
  - WRITE drives the old word with the selected lane replaced.
  - resp_valid at accept+3.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
  - req_ready rises in the cycle after RESP, so there is no back-to-back accept in RESP.
  - resp_rdata/resp_err hold their values until the next RESP.
- Lane mapping is little-endian:
  - addr[1:0]=0 selects bits 7:0; 1 selects 15:8; 2 selects 23:16; 3 selects 31:24.
  - Half lanes: addr[1]=0 selects bits 15:0; addr[1]=1 selects 31:16.
- Extension: LB/LH sign-extend from bit 7/15 of the extracted lane; LBU/LHU zero-extend.
- Address translation (data-segment remap) is the memory's job; addresses pass through untouched except for clearing [1:0].
- Reset mid-operation: abandon the request, no resp_valid, no write committed.

Decomposition:
- Shared `defines.v`:
  - Op code constants (MEM_OP_LW … MEM_OP_SB).
  - State encodings (LSU_IDLE, LSU_READ, LSU_WRITE, LSU_RESP).
  - `WORD_WIDTH.
- One combinational sub-module, lsu_lane, handling extract/sign-extend on the load path and merge on the store path:
  - Inputs: op, addr[1:0], word, wdata.
  - Outputs: load_val, merged_word.
  - Reused by the bench's reference model.

Test Plan:
- Reset, then mem[0x100]=0x8844_22F1.
  - LB at addr 0x100 → resp at accept+2, rdata=0xFFFF_FFF1, err=0.
  - LBU at the same address → rdata=0x0000_00F1.
- mem[0x104]=0x8001_7FFF.
  - LH at 0x106 → rdata=0xFFFF_8001.
  - LHU at 0x106 → 0x0000_8001.
  - LW at 0x104 → 0x8001_7FFF.
- mem[0x108]=0x1122_3344.
  - SB at 0x10A with wdata 0xAB → exactly one write_en pulse at accept+2, write_data=0x11AB_3344, resp at accept+3.
  - A follow-up LW returns 0x11AB_3344.
- SW at 0x10C with wdata 0xDEAD_BEEF → write_en at accept+1, no read_en, resp at accept+2.
- Misaligned requests: LW at 0x101 and SH at 0x103 → resp_valid at accept+1, err=1, rdata=0, read_en and write_en never asserted.
- Reset mid-operation: SH at 0x110 (old word 0xCAFE_0000), rst pulled low during the WRITE cycle → write_en stays 0, memory unchanged, no resp_valid, req_ready=1 after release.
